clk_en_gen: RTL and testbench

CLK_EN_GEN -- requirements
Module: clk_en_gen

---
 rtl/clk_en_pkg.sv | 25 ++
 rtl/clk_en_gen_ce_divider.sv | 42 ++++
 rtl/clk_en_gen.sv | 124 ++++++++++++
 tb/tb_clk_en_gen.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/clk_en_pkg.sv
// Shared types and default constants for the clock-enable generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package clk_en_pkg;

  // Default number of consecutive synchronized-lock cycles before reset release.
  localparam int CLK_EN_STABLE_CYCLES_DFLT = 1024;
  // Default cpu_ce period in clk cycles (even, >= 2).
  localparam int CLK_EN_CPU_DIV_DFLT       = 4;
  // Default pix_ce period in clk cycles (>= 2).
  localparam int CLK_EN_PIX_DIV_DFLT       = 2;

  // Sequencer states: wait for PLL lock, hold it stable, then run the core.
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2
  } clk_en_state_t;

  // Saturating 8-bit increment used by the lock-loss counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/clk_en_gen_ce_divider.sv
// Clock-enable divider: counts 0..div-1 while enabled, pulses ce once per period.
// Latency: first ce is registered div cycles after en rises; ce is a flop output.
// Backpressure: none; en low clears count and ce in the same cycle.
module ce_divider #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div,
  output logic         ce
);

  logic [W-1:0] cnt;
  logic [W-1:0] div_q;
  logic         wrap;

  // The divisor only changes at a period boundary, so a runtime divisor
  // switch can never produce a truncated period.
  assign wrap = (cnt == (div_q - W'(1)));

  // Counter, latched divisor and registered enable pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      div_q <= '0;
      ce    <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      div_q <= div;
      ce    <= 1'b0;
    end else if (wrap) begin
      cnt   <= '0;
      div_q <= div;
      ce    <= 1'b1;
    end else begin
      cnt   <= cnt + W'(1);
      ce    <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_en_gen.sv
// PLL-lock sequencer: syncs pll_locked, holds sys_reset until lock is stable, then runs cpu/pix clock enables.
// Latency: pll_locked to sys_reset release is 2 + STABLE_CYCLES cycles; first cpu_ce/pix_ce CPU_DIV/PIX_DIV cycles after release.
// Backpressure: none; lock loss overrides any pending ce pulse. Optional macro CLK_EN_GEN_TURBO_EN adds the turbo port.
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int STABLE_CYCLES = CLK_EN_STABLE_CYCLES_DFLT,
  parameter int CPU_DIV       = CLK_EN_CPU_DIV_DFLT,
  parameter int PIX_DIV       = CLK_EN_PIX_DIV_DFLT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
`ifdef CLK_EN_GEN_TURBO_EN
  input  logic       turbo,
`endif
  output logic       sys_reset,
  output logic       ready,
  output logic       cpu_ce,
  output logic       pix_ce,
  output logic [7:0] lock_loss_cnt
);

  localparam int SW    = $clog2(STABLE_CYCLES) + 1;
  localparam int CPU_W = $clog2(CPU_DIV + 1);
  localparam int PIX_W = $clog2(PIX_DIV + 1);

  logic               sync_q1;
  logic               locked_s;
  clk_en_state_t      state;
  clk_en_state_t      state_nxt;
  logic [SW-1:0]      stab_cnt;
  logic [SW-1:0]      stab_cnt_nxt;
  logic [7:0]         loss_nxt;
  logic               run_en;
  logic [CPU_W-1:0]   cpu_div_sel;
  logic [PIX_W-1:0]   pix_div_sel;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q1  <= pll_locked;
      locked_s <= sync_q1;
    end
  end

  // State, stability counter, lock-loss counter and registered core reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= WAIT_LOCK;
      stab_cnt      <= '0;
      lock_loss_cnt <= 8'd0;
      sys_reset     <= 1'b1;
    end else begin
      state         <= state_nxt;
      stab_cnt      <= stab_cnt_nxt;
      lock_loss_cnt <= loss_nxt;
      // Registered from next state so reset drops on the RUN entry edge
      // and a dropout in STABILIZE can never pulse it low.
      sys_reset     <= (state_nxt != RUN);
    end
  end

  // Next-state logic; the counter leaves STABILIZE before it could wrap.
  always_comb begin
    state_nxt    = state;
    stab_cnt_nxt = '0;
    loss_nxt     = lock_loss_cnt;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) state_nxt = STABILIZE;
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
        end else if (stab_cnt == SW'(STABLE_CYCLES - 1)) begin
          state_nxt = RUN;
        end else begin
          stab_cnt_nxt = stab_cnt + SW'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          loss_nxt  = sat_inc8(lock_loss_cnt);
        end
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  assign ready = ~sys_reset;

  // Dividers run only while staying in RUN, so the edge that leaves RUN
  // also clears any ce pulse that would have fired on it.
  assign run_en = (state == RUN) && locked_s;

`ifdef CLK_EN_GEN_TURBO_EN
  assign cpu_div_sel = turbo ? CPU_W'(CPU_DIV / 2) : CPU_W'(CPU_DIV);
`else
  assign cpu_div_sel = CPU_W'(CPU_DIV);
`endif
  assign pix_div_sel = PIX_W'(PIX_DIV);

  ce_divider #(.W(CPU_W)) u_cpu_div (
    .clk (clk),
    .rst (rst),
    .en  (run_en),
    .div (cpu_div_sel),
    .ce  (cpu_ce)
  );

  ce_divider #(.W(PIX_W)) u_pix_div (
    .clk (clk),
    .rst (rst),
    .en  (run_en),
    .div (pix_div_sel),
    .ce  (pix_ce)
  );

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen with STABLE_CYCLES=16, CPU_DIV=4, PIX_DIV=2.
// Latency: expected sys_reset release 18 edges after lock is first sampled.
// Backpressure: n/a; inputs change on negedge, outputs are sampled on negedge.
module tb_clk_en_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       turbo;
  logic       sys_reset;
  logic       ready;
  logic       cpu_ce;
  logic       pix_ce;
  logic [7:0] lock_loss_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  clk_en_gen #(
    .STABLE_CYCLES (16),
    .CPU_DIV       (4),
    .PIX_DIV       (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
`ifdef CLK_EN_GEN_TURBO_EN
    .turbo         (turbo),
`endif
    .sys_reset     (sys_reset),
    .ready         (ready),
    .cpu_ce        (cpu_ce),
    .pix_ce        (pix_ce),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One rising edge, then settle to the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    turbo = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Lock is already high; edge index 0 is the first edge that samples it.
  task automatic check_seq(input string name, input int run_at, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      check($sformatf("%s sys_reset k=%0d", name, k), 32'(sys_reset), 32'(k < run_at));
      check($sformatf("%s ready k=%0d", name, k), 32'(ready), 32'(k >= run_at));
      check($sformatf("%s pix_ce k=%0d", name, k), 32'(pix_ce),
            32'((k >= run_at + 2) && ((k - run_at) % 2 == 0)));
      check($sformatf("%s cpu_ce k=%0d", name, k), 32'(cpu_ce),
            32'((k >= run_at + 4) && ((k - run_at) % 4 == 0)));
    end
  endtask

  initial begin
    rst = 1'b1;
    pll_locked = 1'b0;
    turbo = 1'b0;
    step();
    step();

    // Reset values.
    check("rst sys_reset", 32'(sys_reset), 32'd1);
    check("rst ready", 32'(ready), 32'd0);
    check("rst cpu_ce", 32'(cpu_ce), 32'd0);
    check("rst pix_ce", 32'(pix_ce), 32'd0);
    check("rst loss_cnt", 32'(lock_loss_cnt), 32'd0);

    // No lock: stays in reset.
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("nolock sys_reset k=%0d", k), 32'(sys_reset), 32'd1);
    end

    // Stable lock: release at 18, pix from 20 every 2, cpu from 22 every 4.
    pll_locked = 1'b1;
    check_seq("lock", 18, 42);

    // Lock glitch at stabilize count 10: wait restarts, release at 32.
    pulse_reset();
    pll_locked = 1'b1;
    for (int k = 0; k < 38; k++) begin
      step();
      if (k == 12) pll_locked = 1'b0;
      if (k == 13) pll_locked = 1'b1;
      check($sformatf("glitch sys_reset k=%0d", k), 32'(sys_reset), 32'(k < 32));
      check($sformatf("glitch pix_ce k=%0d", k), 32'(pix_ce),
            32'((k >= 34) && ((k - 32) % 2 == 0)));
      check($sformatf("glitch cpu_ce k=%0d", k), 32'(cpu_ce),
            32'((k >= 36) && ((k - 32) % 4 == 0)));
    end

    // Lock loss in RUN timed so both enables would fire on the exit edge (40).
    check("loss cnt before", 32'(lock_loss_cnt), 32'd0);
    pll_locked = 1'b0;
    step();  // edge 38
    check("loss e38 sys_reset", 32'(sys_reset), 32'd0);
    check("loss e38 pix_ce", 32'(pix_ce), 32'd1);
    step();  // edge 39
    check("loss e39 sys_reset", 32'(sys_reset), 32'd0);
    check("loss e39 pix_ce", 32'(pix_ce), 32'd0);
    step();  // edge 40
    check("loss e40 sys_reset", 32'(sys_reset), 32'd1);
    check("loss e40 ready", 32'(ready), 32'd0);
    check("loss e40 cpu_ce suppressed", 32'(cpu_ce), 32'd0);
    check("loss e40 pix_ce suppressed", 32'(pix_ce), 32'd0);
    check("loss e40 cnt", 32'(lock_loss_cnt), 32'd1);

    // Repeated losses: 300 total saturates at 255.
    for (int i = 2; i <= 300; i++) begin
      pll_locked = 1'b1;
      repeat (19) step();
      if (i == 2) check("sat relock sys_reset", 32'(sys_reset), 32'd0);
      pll_locked = 1'b0;
      repeat (3) step();
      if (i == 2)   check("sat cnt 2", 32'(lock_loss_cnt), 32'd2);
      if (i == 254) check("sat cnt 254", 32'(lock_loss_cnt), 32'd254);
      if (i == 255) check("sat cnt 255", 32'(lock_loss_cnt), 32'd255);
    end
    check("sat cnt 300", 32'(lock_loss_cnt), 32'd255);

    // Async reset mid-RUN while pix_ce is high.
    pll_locked = 1'b1;
    repeat (21) step();
    check("arst pre pix_ce", 32'(pix_ce), 32'd1);
    check("arst pre sys_reset", 32'(sys_reset), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("arst sys_reset", 32'(sys_reset), 32'd1);
    check("arst ready", 32'(ready), 32'd0);
    check("arst pix_ce", 32'(pix_ce), 32'd0);
    check("arst cpu_ce", 32'(cpu_ce), 32'd0);
    check("arst loss_cnt", 32'(lock_loss_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_seq("rerun", 18, 26);

`ifdef CLK_EN_GEN_TURBO_EN
    // Turbo on mid-period: period ending at 26 completes, then every 2;
    // turbo off after 33: pulse at 34, then 38, 42.
    pulse_reset();
    pll_locked = 1'b1;
    for (int k = 0; k < 45; k++) begin
      step();
      if (k == 24) turbo = 1'b1;
      if (k == 33) turbo = 1'b0;
      check($sformatf("turbo cpu_ce k=%0d", k), 32'(cpu_ce),
            32'(k == 22 || k == 26 || k == 28 || k == 30 || k == 32 ||
                k == 34 || k == 38 || k == 42));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
